// File: rtl/zap_utlb_pkg.sv
// zap_utlb_pkg: shared types and constants for the ZAP micro-TLB checker.
//   tlb_kind_t    : translation granularity of one entry
//   utlb_entry_t  : one fully-associative TLB entry
//   FSR / DAC / AP / APSR codes and the controller state enum
//   entry_match() : tag compare over the kind-dependent address range
package zap_utlb_pkg;

    typedef enum logic [1:0] {
        KindSection = 2'd0,
        KindLarge   = 2'd1,
        KindSmall   = 2'd2,
        KindFine    = 2'd3
    } tlb_kind_t;

    // tag holds VA[31:10] and pa holds PA[31:10]; low bits are ignored per kind.
    typedef struct packed {
        logic        valid;
        tlb_kind_t   kind;
        logic [21:0] tag;
        logic [21:0] pa;
        logic [7:0]  ap;
        logic [3:0]  dac_sel;
        logic [1:0]  cb;
    } utlb_entry_t;

    localparam logic [3:0] FsrDomSect  = 4'h9;
    localparam logic [3:0] FsrDomPage  = 4'hB;
    localparam logic [3:0] FsrPermSect = 4'hD;
    localparam logic [3:0] FsrPermPage = 4'hF;

    localparam logic [1:0] DacNoAccess = 2'b00;
    localparam logic [1:0] DacClient   = 2'b01;
    localparam logic [1:0] DacReserved = 2'b10;
    localparam logic [1:0] DacManager  = 2'b11;

    localparam logic [1:0] ApSr       = 2'b00;  // access decided by S/R
    localparam logic [1:0] ApPrivOnly = 2'b01;
    localparam logic [1:0] ApUserRo   = 2'b10;
    localparam logic [1:0] ApFull     = 2'b11;

    // {AP,S,R} patterns meaningful when AP == 00
    localparam logic [3:0] ApsrDeny  = 4'b0000;
    localparam logic [3:0] ApsrRom   = 4'b0001;
    localparam logic [3:0] ApsrSysRo = 4'b0010;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCheck = 2'd1,
        StWalk  = 2'd2,
        StResp  = 2'd3
    } utlb_state_t;

    // vpn is VA[31:10]
    function automatic logic entry_match(input utlb_entry_t e, input logic [21:0] vpn);
        logic m;
        unique case (e.kind)
            KindSection: m = (e.tag[21:10] == vpn[21:10]);
            KindLarge:   m = (e.tag[21:6] == vpn[21:6]);
            KindSmall:   m = (e.tag[21:2] == vpn[21:2]);
            KindFine:    m = (e.tag == vpn);
            default:     m = 1'b0;
        endcase
        return e.valid & m;
    endfunction

endpackage

// File: rtl/zap_utlb_perm.sv
// zap_utlb_perm: combinational PA composition and AP/S/R + domain check for one entry.
//   entry     : selected (hit) TLB entry
//   va        : virtual address of the access
//   user/rd/wr: access attributes; sr = {S,R}
//   dac_reg   : domain access control register
//   fsr       : {domain, code}, 0 when the access is allowed
//   phy_addr  : translated address; cacheable: C bit of the entry
module zap_utlb_perm
    import zap_utlb_pkg::*;
(
    input  utlb_entry_t entry,
    input  logic [31:0] va,
    input  logic        user,
    input  logic        rd,
    input  logic        wr,
    input  logic [1:0]  sr,
    input  logic [31:0] dac_reg,
    output logic [7:0]  fsr,
    output logic [31:0] phy_addr,
    output logic        cacheable
);

    logic [1:0] ap_f;
    logic [1:0] dac;
    logic       is_page;
    logic       allow;

    always_comb begin
        phy_addr = {entry.pa[21:10], va[19:0]};
        ap_f     = entry.ap[1:0];
        unique case (entry.kind)
            KindSection: begin
                phy_addr = {entry.pa[21:10], va[19:0]};
                ap_f     = entry.ap[1:0];
            end
            KindLarge: begin
                phy_addr = {entry.pa[21:6], va[15:0]};
                ap_f     = entry.ap[{va[15:14], 1'b0} +: 2];
            end
            KindSmall: begin
                phy_addr = {entry.pa[21:2], va[11:0]};
                ap_f     = entry.ap[{va[11:10], 1'b0} +: 2];
            end
            KindFine: begin
                phy_addr = {entry.pa, va[9:0]};
                ap_f     = entry.ap[1:0];
            end
            default: ;
        endcase
    end

    assign dac     = dac_reg[{entry.dac_sel, 1'b0} +: 2];
    assign is_page = (entry.kind != KindSection);

    always_comb begin
        allow = 1'b0;
        case (ap_f)
            ApFull:     allow = 1'b1;
            ApUserRo:   allow = !user || rd;
            ApPrivOnly: allow = !user;
            default: begin
                case ({ap_f, sr})
                    ApsrRom:   allow = !wr;
                    ApsrSysRo: allow = !user && rd;
                    default:   allow = 1'b0;
                endcase
            end
        endcase
    end

    always_comb begin
        fsr = 8'h00;
        if (dac == DacManager) begin
            fsr = 8'h00;
        end else if (dac == DacClient) begin
            if (!allow) fsr = {entry.dac_sel, is_page ? FsrPermPage : FsrPermSect};
        end else begin
            fsr = {entry.dac_sel, is_page ? FsrDomPage : FsrDomSect};
        end
    end

    assign cacheable = entry.cb[1];

    logic [23:0] unused_bits;
    assign unused_bits = {entry.valid, entry.tag, entry.cb[0]};

endmodule

// File: rtl/zap_utlb_check.sv
// zap_utlb_check: fully-associative micro-TLB with permission check for one ZAP port.
//   i_req_vld/o_req_rdy + i_va, i_rd, i_wr, i_user, i_sr, i_dac_reg, i_mmu_en : lookup
//   o_walk_vld/o_walk_va, i_walk_done/i_walk_fault + refill fields              : page walker
//   o_rsp_vld/i_rsp_rdy + o_phy_addr, o_fsr, o_far, o_cacheable                 : response
//   i_inv : invalidate all entries
module zap_utlb_check
    import zap_utlb_pkg::*;
#(
    parameter int unsigned ENTRIES = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_mmu_en,
    input  logic        i_inv,
    input  logic        i_req_vld,
    output logic        o_req_rdy,
    input  logic [31:0] i_va,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic        i_user,
    input  logic [1:0]  i_sr,
    input  logic [31:0] i_dac_reg,
    output logic        o_walk_vld,
    output logic [31:0] o_walk_va,
    input  logic        i_walk_done,
    input  logic        i_walk_fault,
    input  logic [7:0]  i_walk_fsr,
    input  logic [1:0]  i_walk_kind,
    input  logic [21:0] i_walk_pa,
    input  logic [7:0]  i_walk_ap,
    input  logic [3:0]  i_walk_dac_sel,
    input  logic [1:0]  i_walk_cb,
    output logic        o_rsp_vld,
    input  logic        i_rsp_rdy,
    output logic [31:0] o_phy_addr,
    output logic [7:0]  o_fsr,
    output logic [31:0] o_far,
    output logic        o_cacheable
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    utlb_state_t      state_q, state_d;
    logic [31:0]      va_q, dac_q;
    logic             rd_q, wr_q, user_q, mmu_q;
    logic [1:0]       sr_q;
    utlb_entry_t      tlb_q [ENTRIES];
    logic [IDX_W-1:0] rr_q;
    utlb_entry_t      byp_q;
    logic             byp_hit_q;
    logic             inv_walk_q;
    logic [31:0]      phy_q, far_q;
    logic [7:0]       fsr_q;
    logic             c_q;

    // Parallel lookup: lowest matching index wins; lowest invalid index is the free slot.
    logic             hit, has_free;
    logic [IDX_W-1:0] hit_idx, free_idx;

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (entry_match(tlb_q[i], va_q[31:10])) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!tlb_q[i].valid) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // A refill that raced an invalidate is only visible through the bypass entry.
    utlb_entry_t sel_entry;
    logic        sel_hit;
    assign sel_entry = byp_hit_q ? byp_q : tlb_q[hit_idx];
    assign sel_hit   = byp_hit_q | hit;

    logic [7:0]  perm_fsr;
    logic [31:0] perm_pa;
    logic        perm_c;

    zap_utlb_perm u_perm (
        .entry     (sel_entry),
        .va        (va_q),
        .user      (user_q),
        .rd        (rd_q),
        .wr        (wr_q),
        .sr        (sr_q),
        .dac_reg   (dac_q),
        .fsr       (perm_fsr),
        .phy_addr  (perm_pa),
        .cacheable (perm_c)
    );

    utlb_entry_t      refill;
    logic             walk_ok, install, to_bypass;
    logic [IDX_W-1:0] ins_idx;

    always_comb begin
        refill         = '0;
        refill.valid   = 1'b1;
        refill.kind    = tlb_kind_t'(i_walk_kind);
        refill.tag     = va_q[31:10];
        refill.pa      = i_walk_pa;
        refill.ap      = i_walk_ap;
        refill.dac_sel = i_walk_dac_sel;
        refill.cb      = i_walk_cb;
    end

    assign walk_ok   = (state_q == StWalk) && i_walk_done && !i_walk_fault;
    assign install   = walk_ok && !inv_walk_q && !i_inv;
    assign to_bypass = walk_ok && (inv_walk_q || i_inv);
    assign ins_idx   = has_free ? free_idx : rr_q;

    logic        load_rsp;
    logic [31:0] rsp_pa;
    logic [7:0]  rsp_fsr;
    logic        rsp_c;

    always_comb begin
        state_d  = state_q;
        load_rsp = 1'b0;
        rsp_pa   = va_q;
        rsp_fsr  = 8'h00;
        rsp_c    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_req_vld) state_d = StCheck;
            end
            StCheck: begin
                if (!mmu_q || !(rd_q || wr_q)) begin
                    state_d  = StResp;
                    load_rsp = 1'b1;
                end else if (sel_hit) begin
                    state_d  = StResp;
                    load_rsp = 1'b1;
                    rsp_pa   = perm_pa;
                    rsp_fsr  = perm_fsr;
                    rsp_c    = perm_c;
                end else begin
                    state_d = StWalk;
                end
            end
            StWalk: begin
                if (i_walk_fault) begin
                    state_d  = StResp;
                    load_rsp = 1'b1;
                    rsp_fsr  = i_walk_fsr;
                end else if (i_walk_done) begin
                    state_d = StCheck;
                end
            end
            StResp: begin
                if (i_rsp_rdy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            va_q   <= '0;
            dac_q  <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            user_q <= 1'b0;
            mmu_q  <= 1'b0;
            sr_q   <= '0;
        end else if (state_q == StIdle && i_req_vld) begin
            va_q   <= i_va;
            dac_q  <= i_dac_reg;
            rd_q   <= i_rd;
            wr_q   <= i_wr;
            user_q <= i_user;
            mmu_q  <= i_mmu_en;
            sr_q   <= i_sr;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) tlb_q[i] <= '0;
            rr_q <= '0;
        end else if (i_inv) begin
            for (int i = 0; i < int'(ENTRIES); i++) tlb_q[i].valid <= 1'b0;
        end else if (install) begin
            tlb_q[ins_idx] <= refill;
            if (!has_free) rr_q <= rr_q + 1'b1;  // power-of-two depth wraps naturally
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            byp_q      <= '0;
            byp_hit_q  <= 1'b0;
            inv_walk_q <= 1'b0;
        end else begin
            if (state_q == StWalk) inv_walk_q <= inv_walk_q | i_inv;
            else                   inv_walk_q <= 1'b0;
            if (to_bypass) begin
                byp_q     <= refill;
                byp_hit_q <= 1'b1;
            end else if (state_q == StResp && i_rsp_rdy) begin
                byp_hit_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            phy_q <= '0;
            fsr_q <= '0;
            far_q <= '0;
            c_q   <= 1'b0;
        end else if (load_rsp) begin
            phy_q <= rsp_pa;
            fsr_q <= rsp_fsr;
            far_q <= va_q;
            c_q   <= rsp_c;
        end
    end

    assign o_req_rdy   = (state_q == StIdle);
    assign o_walk_vld  = (state_q == StWalk);
    assign o_walk_va   = o_walk_vld ? va_q : '0;
    assign o_rsp_vld   = (state_q == StResp);
    assign o_phy_addr  = phy_q;
    assign o_fsr       = fsr_q;
    assign o_far       = far_q;
    assign o_cacheable = c_q;

endmodule

// File: tb/tb_zap_utlb_check.sv
module tb_zap_utlb_check;

    localparam int ENTRIES = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mmu_en, inv, req_vld, req_rdy, rd, wr, user;
    logic [31:0] va, dac_reg;
    logic [1:0]  sr;
    logic        walk_vld, walk_done, walk_fault;
    logic [31:0] walk_va;
    logic [7:0]  walk_fsr, walk_ap;
    logic [1:0]  walk_kind, walk_cb;
    logic [21:0] walk_pa;
    logic [3:0]  walk_dac_sel;
    logic        rsp_vld, rsp_rdy, cacheable;
    logic [31:0] phy_addr, far;
    logic [7:0]  fsr;

    always #5 clk = ~clk;

    zap_utlb_check #(.ENTRIES(ENTRIES)) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_mmu_en       (mmu_en),
        .i_inv          (inv),
        .i_req_vld      (req_vld),
        .o_req_rdy      (req_rdy),
        .i_va           (va),
        .i_rd           (rd),
        .i_wr           (wr),
        .i_user         (user),
        .i_sr           (sr),
        .i_dac_reg      (dac_reg),
        .o_walk_vld     (walk_vld),
        .o_walk_va      (walk_va),
        .i_walk_done    (walk_done),
        .i_walk_fault   (walk_fault),
        .i_walk_fsr     (walk_fsr),
        .i_walk_kind    (walk_kind),
        .i_walk_pa      (walk_pa),
        .i_walk_ap      (walk_ap),
        .i_walk_dac_sel (walk_dac_sel),
        .i_walk_cb      (walk_cb),
        .o_rsp_vld      (rsp_vld),
        .i_rsp_rdy      (rsp_rdy),
        .o_phy_addr     (phy_addr),
        .o_fsr          (fsr),
        .o_far          (far),
        .o_cacheable    (cacheable)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference TLB: list of translations with their base VA.
    bit          m_valid [ENTRIES];
    int          m_kind  [ENTRIES];
    logic [31:0] m_va    [ENTRIES];
    logic [21:0] m_pa    [ENTRIES];
    logic [7:0]  m_ap    [ENTRIES];
    logic [3:0]  m_dom   [ENTRIES];
    logic [1:0]  m_cb    [ENTRIES];
    int          m_rr = 0;

    // What the walker answers with for the next walk.
    int          w_kind;
    logic [21:0] w_pa;
    logic [7:0]  w_ap;
    logic [3:0]  w_dom;
    logic [1:0]  w_cb;
    bit          w_fault = 0;
    logic [7:0]  w_fsr = 8'h00;

    logic [31:0] exp_pa, exp_va;
    logic [7:0]  exp_fsr;
    logic        exp_c;
    bit          armed = 0;
    logic [31:0] last_pa;
    logic [7:0]  last_fsr;
    logic        last_c;
    int          last_walks;

    function automatic int page_shift(input int kind);
        case (kind)
            0:       return 20;
            1:       return 16;
            2:       return 12;
            default: return 10;
        endcase
    endfunction

    function automatic void model_resp(input int kind, input logic [21:0] pa,
                                       input logic [7:0] ap, input logic [3:0] dom,
                                       input logic [1:0] cb, input logic [31:0] a,
                                       input bit r, input bit w, input bit u,
                                       input logic [1:0] s, input logic [31:0] dac,
                                       output logic [31:0] opa, output logic [7:0] ofsr,
                                       output logic oc);
        int          sh;
        logic [31:0] mask;
        int          apf;
        int          d;
        bit          page;
        bit          ok;
        sh   = page_shift(kind);
        mask = (32'd1 << sh) - 32'd1;
        opa  = ({pa, 10'b0} & ~mask) | (a & mask);
        if (kind == 2)      apf = int'((ap >> (2 * int'(a[11:10]))) & 8'h3);
        else if (kind == 1) apf = int'((ap >> (2 * int'(a[15:14]))) & 8'h3);
        else                apf = int'(ap & 8'h3);
        d    = int'((dac >> (2 * int'(dom))) & 32'h3);
        page = (kind != 0);
        if (d == 3) begin
            ofsr = 8'h00;
        end else if (d != 1) begin
            ofsr = {dom, page ? 4'hB : 4'h9};
        end else begin
            if (apf == 3)       ok = 1;
            else if (apf == 2)  ok = !u || r;
            else if (apf == 1)  ok = !u;
            else if (s == 2'b01) ok = !w;
            else if (s == 2'b10) ok = !u && r;
            else                ok = 0;
            ofsr = ok ? 8'h00 : {dom, page ? 4'hF : 4'hD};
        end
        oc = cb[1];
    endfunction

    function automatic int model_find(input logic [31:0] a);
        for (int i = 0; i < ENTRIES; i++) begin
            if (m_valid[i] && ((a >> page_shift(m_kind[i])) ==
                               (m_va[i] >> page_shift(m_kind[i])))) return i;
        end
        return -1;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
    endfunction

    function automatic void model_install(input logic [31:0] a);
        int idx;
        idx = -1;
        for (int i = ENTRIES - 1; i >= 0; i--) if (!m_valid[i]) idx = i;
        if (idx < 0) begin
            idx  = m_rr;
            m_rr = (m_rr + 1) % ENTRIES;
        end
        m_valid[idx] = 1;
        m_kind[idx]  = w_kind;
        m_va[idx]    = a;
        m_pa[idx]    = w_pa;
        m_ap[idx]    = w_ap;
        m_dom[idx]   = w_dom;
        m_cb[idx]    = w_cb;
    endfunction

    // Compare process: response fields and walk address whenever they are meaningful.
    always @(negedge clk) begin
        if (rst_n && armed) begin
            if (rsp_vld) begin
                chk("rsp_pa", phy_addr, exp_pa);
                chk("rsp_fsr", {24'h0, fsr}, {24'h0, exp_fsr});
                chk("rsp_far", far, exp_va);
                chk("rsp_c", {31'h0, cacheable}, {31'h0, exp_c});
                chk("rdy_busy", {31'h0, req_rdy}, 32'd0);
                last_pa  = phy_addr;
                last_fsr = fsr;
                last_c   = cacheable;
            end
            if (walk_vld) chk("walk_va", walk_va, exp_va);
        end
    end

    task automatic txn(input string name, input logic [31:0] a, input bit r, input bit w,
                       input bit u, input logic [1:0] s, input logic [31:0] dac,
                       input bit mmu, input bit inv_walk);
        int idx;
        int walks;
        int lat;
        bit exp_walk;
        walks    = 0;
        exp_walk = 0;
        exp_va   = a;
        idx      = model_find(a);
        if (!mmu || !(r || w)) begin
            exp_pa = a; exp_fsr = 8'h00; exp_c = 1'b0;
        end else if (idx >= 0) begin
            model_resp(m_kind[idx], m_pa[idx], m_ap[idx], m_dom[idx], m_cb[idx],
                       a, r, w, u, s, dac, exp_pa, exp_fsr, exp_c);
        end else begin
            exp_walk = 1;
            if (w_fault) begin
                exp_pa = a; exp_fsr = w_fsr; exp_c = 1'b0;
            end else begin
                model_resp(w_kind, w_pa, w_ap, w_dom, w_cb, a, r, w, u, s, dac,
                           exp_pa, exp_fsr, exp_c);
            end
        end
        if (exp_walk && !w_fault) begin
            if (inv_walk) model_clear();
            else          model_install(a);
        end
        armed = 1;
        chk({name, "_rdy"}, {31'h0, req_rdy}, 32'd1);
        req_vld = 1; va = a; rd = r; wr = w; user = u; sr = s; dac_reg = dac; mmu_en = mmu;
        @(posedge clk); #1;
        req_vld = 0;
        lat = 1;
        while (!rsp_vld && lat < 60) begin
            if (walk_vld) begin
                walks++;
                @(posedge clk); #1; lat++;
                if (inv_walk) begin
                    inv = 1;
                    @(posedge clk); #1; lat++;
                    inv = 0;
                end
                walk_kind = w_kind[1:0]; walk_pa = w_pa; walk_ap = w_ap;
                walk_dac_sel = w_dom; walk_cb = w_cb; walk_fsr = w_fsr;
                walk_done = !w_fault; walk_fault = w_fault;
                @(posedge clk); #1; lat++;
                walk_done = 0; walk_fault = 0;
            end else begin
                @(posedge clk); #1; lat++;
            end
        end
        last_walks = walks;
        chk({name, "_rspvld"}, {31'h0, rsp_vld}, 32'd1);
        chk({name, "_walks"}, walks, {31'h0, exp_walk});
        if (!exp_walk) chk({name, "_lat"}, lat, 32'd2);
        @(posedge clk); #1;  // hold one cycle without ready: outputs must stay put
        rsp_rdy = 1;
        @(posedge clk); #1;
        rsp_rdy = 0;
        chk({name, "_done"}, {31'h0, rsp_vld}, 32'd0);
        armed = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        mmu_en = 0; inv = 0; req_vld = 0; va = '0; rd = 0; wr = 0; user = 0; sr = '0;
        dac_reg = '0; walk_done = 0; walk_fault = 0; walk_fsr = '0; walk_kind = '0;
        walk_pa = '0; walk_ap = '0; walk_dac_sel = '0; walk_cb = '0; rsp_rdy = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_rdy", {31'h0, req_rdy}, 32'd1);
        chk("rst_walk_vld", {31'h0, walk_vld}, 32'd0);
        chk("rst_walk_va", walk_va, 32'd0);
        chk("rst_rsp_vld", {31'h0, rsp_vld}, 32'd0);
        chk("rst_pa", phy_addr, 32'd0);
        chk("rst_fsr", {24'h0, fsr}, 32'd0);
        chk("rst_far", far, 32'd0);
        chk("rst_c", {31'h0, cacheable}, 32'd0);
        rst_n = 1;
        @(posedge clk); #1;

        // MMU off: identity, no walk
        txn("mmuoff", 32'h1234_5678, 1, 0, 0, 2'b00, 32'h10, 0, 0);
        chk("lit_mmuoff_pa", last_pa, 32'h1234_5678);

        // Section miss then hit
        w_kind = 0; w_pa = 22'h200400; w_ap = 8'h03; w_dom = 4'd2; w_cb = 2'b10;
        txn("sect_miss", 32'h0010_0ABC, 1, 0, 0, 2'b00, 32'h10, 1, 0);
        chk("lit_sect_pa", last_pa, 32'h8010_0ABC);
        chk("lit_sect_fsr", {24'h0, last_fsr}, 32'h0);
        chk("lit_sect_c", {31'h0, last_c}, 32'd1);
        txn("sect_hit", 32'h0010_0ABC, 1, 0, 0, 2'b00, 32'h10, 1, 0);

        // Small page permission / domain checks
        w_kind = 2; w_pa = 22'h003001; w_ap = 8'h1B; w_dom = 4'd3; w_cb = 2'b11;
        txn("small_perm", 32'h0040_0800, 0, 1, 1, 2'b00, 32'h50, 1, 0);
        chk("lit_small_fsr", {24'h0, last_fsr}, 32'h3F);
        chk("lit_small_pa", last_pa, 32'h00C0_0800);
        txn("small_dom", 32'h0040_0800, 0, 1, 1, 2'b00, 32'h10, 1, 0);
        chk("lit_dom_fsr", {24'h0, last_fsr}, 32'h3B);
        txn("small_mgr", 32'h0040_0800, 1, 0, 1, 2'b00, 32'hC0, 1, 0);
        txn("small_rom", 32'h0040_0C00, 1, 0, 1, 2'b01, 32'h40, 1, 0);
        txn("small_deny", 32'h0040_0C00, 1, 0, 0, 2'b00, 32'h40, 1, 0);
        txn("small_sysro", 32'h0040_0C04, 1, 0, 0, 2'b10, 32'h40, 1, 0);

        // Walker fault: no install, so the same VA walks again
        w_fault = 1; w_fsr = 8'h05;
        txn("fault1", 32'h0500_0000, 1, 0, 0, 2'b00, 32'h10, 1, 0);
        chk("lit_fault_fsr", {24'h0, last_fsr}, 32'h05);
        txn("fault2", 32'h0500_0000, 1, 0, 0, 2'b00, 32'h10, 1, 0);
        chk("lit_fault_rewalk", last_walks, 32'd1);
        w_fault = 0; w_fsr = 8'h00;

        // Invalidate during walk: refill used once via bypass, then misses again
        w_kind = 1; w_pa = 22'h0A8000; w_ap = 8'hFF; w_dom = 4'd2; w_cb = 2'b01;
        txn("inv_walk", 32'h0600_4123, 1, 1, 1, 2'b00, 32'h10, 1, 1);
        chk("lit_inv_pa", last_pa, 32'h2A00_4123);
        txn("inv_rewalk", 32'h0600_4123, 1, 0, 0, 2'b00, 32'h10, 1, 0);
        chk("lit_inv_rewalk", last_walks, 32'd1);

        // MMU on but neither read nor write: identity
        txn("noacc", 32'h0600_4123, 0, 0, 0, 2'b00, 32'h10, 1, 0);

        // Standalone invalidate, then fill ENTRIES+2 sections
        @(posedge clk); #1; inv = 1;
        @(posedge clk); #1; inv = 0;
        model_clear();
        w_ap = 8'h03; w_dom = 4'd2; w_cb = 2'b10; w_kind = 0;
        for (int i = 0; i < ENTRIES + 2; i++) begin
            w_pa = {12'(12'h300 + i), 10'b0};
            txn("fill", (32'h100 + i) << 20, 1, 0, 0, 2'b00, 32'h10, 1, 0);
        end
        w_pa = 22'h3FF000;
        txn("evict0", 32'h1000_0000, 1, 0, 0, 2'b00, 32'h10, 1, 0);
        chk("lit_evict0_walk", last_walks, 32'd1);
        txn("evict1", 32'h1010_0000, 1, 0, 0, 2'b00, 32'h10, 1, 0);
        chk("lit_evict1_walk", last_walks, 32'd1);
        txn("keep4", 32'h1040_0000, 1, 0, 0, 2'b00, 32'h10, 1, 0);
        txn("keep9", 32'h1090_0000, 1, 0, 0, 2'b00, 32'h10, 1, 0);
        chk("lit_keep9_pa", last_pa, 32'h3090_0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
